// File: rtl/classifier_argmax_scorer_if.sv
// classifier_argmax_scorer_if: request/result bundle for the arg-max scorer.
// master drives start/scores/label/clear; slave returns pred and accuracy counts.
interface classifier_argmax_scorer_if #(
  parameter int BITSIZE   = 16,
  parameter int NUM_CLASS = 2,
  parameter int LBL_W     = $clog2(NUM_CLASS),
  parameter int CNT_W     = 16
);
  logic                         start;
  logic [BITSIZE*NUM_CLASS-1:0] scores;
  logic [LBL_W-1:0]             label;
  logic                         clear;
  logic                         busy;
  logic [LBL_W-1:0]             pred;
  logic                         pred_valid;
  logic                         correct;
  logic [CNT_W-1:0]             total_cnt;
  logic [CNT_W-1:0]             correct_cnt;

  modport master (
    output start, scores, label, clear,
    input  busy, pred, pred_valid, correct,
    input  total_cnt, correct_cnt
  );

  modport slave (
    input  start, scores, label, clear,
    output busy, pred, pred_valid, correct,
    output total_cnt, correct_cnt
  );
endinterface

// File: rtl/classifier_argmax_scorer.sv
// classifier_argmax_scorer: sign-magnitude arg-max over NUM_CLASS scores, one class per cycle.
// Label compare and accuracy counters exist only with CLASSIFIER_ARGMAX_ACC_EN defined.
module classifier_argmax_scorer #(
  parameter int BITSIZE   = 16,
  parameter int NUM_CLASS = 2,
  parameter int LBL_W     = $clog2(NUM_CLASS),
  parameter int CNT_W     = 16
) (
  input logic clk,
  input logic reset,
  classifier_argmax_scorer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef logic [BITSIZE-1:0] score_t;

  localparam logic [LBL_W-1:0] LAST = LBL_W'(NUM_CLASS - 1);

  state_t           state;
  score_t           cls_in [NUM_CLASS];
  score_t           cls_q  [NUM_CLASS];
  score_t           best_val;
  logic [LBL_W-1:0] best_idx;
  logic [LBL_W-1:0] idx;
  logic [LBL_W-1:0] pred_q;
  logic             busy_q;
  logic             pv_q;
  logic             take;

  // -0 is folded onto +0 so the two compare equal
  function automatic logic sm_gt(score_t a, score_t b);
    logic a_neg;
    logic b_neg;
    a_neg = a[BITSIZE-1] && (a[BITSIZE-2:0] != '0);
    b_neg = b[BITSIZE-1] && (b[BITSIZE-2:0] != '0);
    if (a_neg != b_neg) return b_neg;
    if (a_neg) return a[BITSIZE-2:0] < b[BITSIZE-2:0];
    return a[BITSIZE-2:0] > b[BITSIZE-2:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CLASS; i++)
      cls_in[i] = bus.scores[(NUM_CLASS-1-i)*BITSIZE +: BITSIZE];
  end

  assign take = sm_gt(cls_q[idx], best_val);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      pv_q     <= 1'b0;
      pred_q   <= '0;
      best_val <= '0;
      best_idx <= '0;
      idx      <= '0;
      for (int i = 0; i < NUM_CLASS; i++)
        cls_q[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          pv_q <= 1'b0;
          // busy drops one cycle after the result strobe
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (bus.start) begin
            cls_q    <= cls_in;
            best_val <= cls_in[0];
            best_idx <= '0;
            idx      <= LBL_W'(1);
            busy_q   <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (take) begin
            best_val <= cls_q[idx];
            best_idx <= idx;
          end
          if (idx == LAST) state <= DONE;
          else idx <= idx + 1'b1;
        end
        DONE: begin
          pred_q <= best_idx;
          pv_q   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.pred       = pred_q;
  assign bus.pred_valid = pv_q;

`ifdef CLASSIFIER_ARGMAX_ACC_EN
  localparam logic [LBL_W:0]   NCLS = (LBL_W+1)'(NUM_CLASS);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [LBL_W-1:0] label_q;
  logic             hit;
  logic             correct_q;
  logic [CNT_W-1:0] tot_q;
  logic [CNT_W-1:0] cor_q;

  assign hit = ({1'b0, label_q} < NCLS) && (best_idx == label_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      label_q   <= '0;
      correct_q <= 1'b0;
      tot_q     <= '0;
      cor_q     <= '0;
    end else begin
      if (state == IDLE && !busy_q && bus.start)
        label_q <= bus.label;
      if (state == DONE)
        correct_q <= hit;
      if (bus.clear) begin
        tot_q <= '0;
        cor_q <= '0;
      end else if (state == DONE) begin
        if (tot_q != CMAX) tot_q <= tot_q + 1'b1;
        if (hit && cor_q != CMAX) cor_q <= cor_q + 1'b1;
      end
    end
  end

  assign bus.correct     = correct_q;
  assign bus.total_cnt   = tot_q;
  assign bus.correct_cnt = cor_q;
`else
  logic unused_acc;
  assign unused_acc      = ^{bus.label, bus.clear};
  assign bus.correct     = 1'b0;
  assign bus.total_cnt   = '0;
  assign bus.correct_cnt = '0;
`endif

endmodule
